// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
// The range helper is used by both the round-key store and the controller.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_NUM_RKEYS  = 11;
    localparam int AES_KEY_W      = 128;
    localparam int RK_IDX_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } key_sched_state_t;

    function automatic logic rk_idx_in_range(input logic [RK_IDX_W-1:0] idx);
        return idx <= RK_IDX_W'(AES_NUM_ROUNDS);
    endfunction

endpackage

// File: rtl/aes_rkey_store.sv
// Eleven-entry round-key register file: one synchronous write port and one
// registered, range-checked read port that answers every request next cycle.
module aes_rkey_store
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [RK_IDX_W-1:0]  wr_idx,
    input  logic [AES_KEY_W-1:0] wr_data,
    input  logic                 keys_valid,
    input  logic                 rd_req,
    input  logic [RK_IDX_W-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic [AES_KEY_W-1:0] rd_data
);

    logic [AES_KEY_W-1:0] rk_r [AES_NUM_RKEYS];
    logic                 rd_valid_r;
    logic                 rd_err_r;
    logic [AES_KEY_W-1:0] rd_data_r;

    // Round-key storage; out-of-range write indices are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < AES_NUM_RKEYS; i++) begin
                rk_r[i] <= {AES_KEY_W{1'b0}};
            end
        end else if (wr_en && rk_idx_in_range(wr_idx)) begin
            rk_r[wr_idx] <= wr_data;
        end
    end

    // Read response; sees the pre-write contents when a write lands on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_data_r  <= {AES_KEY_W{1'b0}};
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req) begin
                if (keys_valid && rk_idx_in_range(rd_idx)) begin
                    rd_data_r <= rk_r[rd_idx];
                    rd_err_r  <= 1'b0;
                end else begin
                    rd_data_r <= {AES_KEY_W{1'b0}};
                    rd_err_r  <= 1'b1;
                end
            end else begin
                rd_err_r <= 1'b0;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_err   = rd_err_r;
    assign rd_data  = rd_data_r;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key scheduler: drives the key-expansion handshake, collects
// the ten expanded round keys and serves all eleven to the cipher datapath.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           key_load,
    input  logic [127:0]   key_in,
    output logic           kx_enable,
    output logic [127:0]   kx_key,
    output logic           kx_key_ack,
    input  logic           kx_key_ready,
    input  logic [3:0]     kx_key_transform,
    input  logic [127:0]   kx_key_out,
    input  logic           kx_state_error,
    input  logic           rk_req,
    input  logic [3:0]     rk_idx,
    output logic           rk_valid,
    output logic [127:0]   rk_data,
    output logic           rk_err,
    output logic           keys_valid,
    output logic           busy,
    output logic           error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    key_sched_state_t     state_r, state_nxt_s;
    logic [RK_IDX_W-1:0]  exp_idx_r, exp_idx_nxt_s;
    logic [TMO_W-1:0]     tmo_cnt_r, tmo_cnt_nxt_s;
    logic                 kx_enable_r, kx_enable_nxt_s;
    logic [AES_KEY_W-1:0] kx_key_r, kx_key_nxt_s;
    logic                 kx_key_ack_r, kx_key_ack_nxt_s;
    logic                 keys_valid_r, keys_valid_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 error_r, error_nxt_s;
    logic                 wr_en_s;
    logic [RK_IDX_W-1:0]  wr_idx_s;
    logic [AES_KEY_W-1:0] wr_data_s;
    logic                 capture_s;
    logic                 timeout_s;
    logic                 enter_err_s;

    // The round-number match rejects the ready that lingers one cycle past an ack.
    assign capture_s   = kx_key_ready && (kx_key_transform == exp_idx_r);
    assign timeout_s   = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
    assign enter_err_s = (state_nxt_s == ST_ERROR) && (state_r != ST_ERROR);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; expansion errors outrank everything, a capture outranks the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                state_nxt_s = key_load ? ST_START : state_r;
            end
            ST_START: begin
                state_nxt_s = kx_state_error ? ST_ERROR : ST_WAIT;
            end
            ST_WAIT: begin
                if (kx_state_error) begin
                    state_nxt_s = ST_ERROR;
                end else if (capture_s) begin
                    state_nxt_s = ST_ACK;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                if (kx_state_error) begin
                    state_nxt_s = ST_ERROR;
                end else if (exp_idx_r == RK_IDX_W'(AES_NUM_ROUNDS)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, counters and the store write port.
    always_comb begin
        exp_idx_nxt_s    = exp_idx_r;
        tmo_cnt_nxt_s    = tmo_cnt_r;
        kx_enable_nxt_s  = kx_enable_r;
        kx_key_nxt_s     = kx_key_r;
        kx_key_ack_nxt_s = kx_key_ack_r;
        keys_valid_nxt_s = keys_valid_r;
        busy_nxt_s       = busy_r;
        error_nxt_s      = error_r;
        wr_en_s          = 1'b0;
        wr_idx_s         = exp_idx_r;
        wr_data_s        = kx_key_out;
        if (enter_err_s) begin
            kx_enable_nxt_s  = 1'b0;
            kx_key_ack_nxt_s = 1'b0;
            busy_nxt_s       = 1'b0;
            keys_valid_nxt_s = 1'b0;
            error_nxt_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (key_load) begin
                        kx_key_nxt_s     = key_in;
                        exp_idx_nxt_s    = RK_IDX_W'(1);
                        keys_valid_nxt_s = 1'b0;
                        error_nxt_s      = 1'b0;
                        busy_nxt_s       = 1'b1;
                        wr_en_s          = 1'b1;
                        wr_idx_s         = {RK_IDX_W{1'b0}};
                        wr_data_s        = key_in;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_START: begin
                    kx_enable_nxt_s = 1'b1;
                    tmo_cnt_nxt_s   = {TMO_W{1'b0}};
                end
                ST_WAIT: begin
                    if (capture_s) begin
                        wr_en_s          = 1'b1;
                        kx_key_ack_nxt_s = 1'b1;
                    end else begin
                        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_ACK: begin
                    kx_key_ack_nxt_s = 1'b0;
                    if (exp_idx_r == RK_IDX_W'(AES_NUM_ROUNDS)) begin
                        kx_enable_nxt_s  = 1'b0;
                        busy_nxt_s       = 1'b0;
                        keys_valid_nxt_s = 1'b1;
                    end else begin
                        exp_idx_nxt_s = exp_idx_r + RK_IDX_W'(1);
                        tmo_cnt_nxt_s = {TMO_W{1'b0}};
                    end
                end
                default: begin
                    kx_key_ack_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_idx_r    <= {RK_IDX_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            kx_enable_r  <= 1'b0;
            kx_key_r     <= {AES_KEY_W{1'b0}};
            kx_key_ack_r <= 1'b0;
            keys_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            exp_idx_r    <= exp_idx_nxt_s;
            tmo_cnt_r    <= tmo_cnt_nxt_s;
            kx_enable_r  <= kx_enable_nxt_s;
            kx_key_r     <= kx_key_nxt_s;
            kx_key_ack_r <= kx_key_ack_nxt_s;
            keys_valid_r <= keys_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            error_r      <= error_nxt_s;
        end
    end

    aes_rkey_store u_store (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_s),
        .wr_idx     (wr_idx_s),
        .wr_data    (wr_data_s),
        .keys_valid (keys_valid_r),
        .rd_req     (rk_req),
        .rd_idx     (rk_idx),
        .rd_valid   (rk_valid),
        .rd_err     (rk_err),
        .rd_data    (rk_data)
    );

    assign kx_enable  = kx_enable_r;
    assign kx_key     = kx_key_r;
    assign kx_key_ack = kx_key_ack_r;
    assign keys_valid = keys_valid_r;
    assign busy       = busy_r;
    assign error      = error_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural key-expansion stub
// that replays the FIPS-197 round keys for 2b7e1516...09cf4f3c.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         kx_enable;
    logic [127:0] kx_key;
    logic         kx_key_ack;
    logic         kx_key_ready;
    logic [3:0]   kx_key_transform;
    logic [127:0] kx_key_out;
    logic         inj_err = 1'b0;
    logic         rk_req = 1'b0;
    logic [3:0]   rk_idx = 4'd0;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;
    logic         keys_valid;
    logic         busy;
    logic         error;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] golden [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int ack_base = 0;
    int stall_round = 99;
    int stale_hold  = 1;

    aes_key_sched_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .key_load         (key_load),
        .key_in           (key_in),
        .kx_enable        (kx_enable),
        .kx_key           (kx_key),
        .kx_key_ack       (kx_key_ack),
        .kx_key_ready     (kx_key_ready),
        .kx_key_transform (kx_key_transform),
        .kx_key_out       (kx_key_out),
        .kx_state_error   (inj_err),
        .rk_req           (rk_req),
        .rk_idx           (rk_idx),
        .rk_valid         (rk_valid),
        .rk_data          (rk_data),
        .rk_err           (rk_err),
        .keys_valid       (keys_valid),
        .busy             (busy),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Every cycle the ack is high counts, so a two-cycle ack shows up as an extra count.
    always @(posedge clk) begin
        if (kx_key_ack) ack_cnt <= ack_cnt + 1;
    end

    // Expansion stub: ready four cycles into each round, ready lingers stale_hold cycles after an ack.
    logic st_en_q;
    int   st_round, st_cnt, st_hold;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_en_q <= 1'b0; st_round <= 0; st_cnt <= 0; st_hold <= 0;
            kx_key_ready <= 1'b0; kx_key_transform <= 4'd0; kx_key_out <= 128'h0;
        end else begin
            st_en_q <= kx_enable;
            if (kx_enable && !st_en_q) begin
                st_round <= 1; st_cnt <= 0; st_hold <= 0; kx_key_ready <= 1'b0;
            end else if (!kx_enable) begin
                st_round <= 0; st_hold <= 0; kx_key_ready <= 1'b0;
            end else if (kx_key_ack) begin
                st_hold <= stale_hold; st_cnt <= 0; st_round <= st_round + 1;
            end else if (st_hold > 0) begin
                st_hold <= st_hold - 1;
                if (st_hold == 1) kx_key_ready <= 1'b0;
            end else if (!kx_key_ready && st_round >= 1 && st_round <= 10 && st_round != stall_round) begin
                if (st_cnt == 3) begin
                    kx_key_ready <= 1'b1;
                    kx_key_transform <= 4'(st_round);
                    kx_key_out <= golden[st_round];
                    st_cnt <= 0;
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_kx_enable"}, kx_enable, 0);
        chk({tag, "_kx_key"}, kx_key, 0);
        chk({tag, "_kx_key_ack"}, kx_key_ack, 0);
        chk({tag, "_rk_valid"}, rk_valid, 0);
        chk({tag, "_rk_data"}, rk_data, 0);
        chk({tag, "_rk_err"}, rk_err, 0);
        chk({tag, "_keys_valid"}, keys_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic do_load(input logic [127:0] key);
        key_in = key;
        key_load = 1'b1;
        ack_base = ack_cnt;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_acks(input int n);
        int k = 0;
        while ((ack_cnt - ack_base) < n && k < 500) begin
            tick();
            k++;
        end
        chk($sformatf("ack_%0d_reached", n), ((ack_cnt - ack_base) >= n), 1);
    endtask

    task automatic wait_done(input string tag);
        int   k = 0;
        logic prev_ack = 1'b0;
        while (!keys_valid && k < 1000) begin
            prev_ack = kx_key_ack;
            tick();
            k++;
        end
        chk({tag, "_keys_valid"}, keys_valid, 1);
        chk({tag, "_kv_after_ack"}, prev_ack, 1);
        chk({tag, "_ack_count"}, ack_cnt - ack_base, 10);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_kx_enable"}, kx_enable, 0);
    endtask

    task automatic rd(input logic [3:0] idx, input logic exp_err, input logic [127:0] exp_data);
        rk_req = 1'b1;
        rk_idx = idx;
        tick();
        rk_req = 1'b0;
        chk($sformatf("rd%0d_valid", idx), rk_valid, 1);
        chk($sformatf("rd%0d_err", idx), rk_err, exp_err);
        chk($sformatf("rd%0d_data", idx), rk_data, exp_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset and idle state
        tick(); tick();
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        tick();
        chk_all_zero("after_reset");
        rd(4'd0, 1'b1, 128'h0);
        tick();
        chk("rd_valid_one_cycle", rk_valid, 0);

        // Full expansion of the FIPS-197 key
        do_load(KEY_A);
        chk("load_busy", busy, 1);
        chk("load_kx_key", kx_key, KEY_A);
        chk("load_kx_enable_low", kx_enable, 0);
        tick();
        chk("start_kx_enable", kx_enable, 1);
        wait_done("exp1");
        chk("exp1_error", error, 0);
        for (int i = 0; i <= 10; i++) rd(4'(i), 1'b0, golden[i]);
        rd(4'd11, 1'b1, 128'h0);
        rd(4'd5, 1'b0, golden[5]);
        tick();
        chk("rd_data_holds", rk_data, golden[5]);

        // Load and read in the same cycle from DONE, with ready lingering two cycles per ack
        stale_hold = 2;
        rk_req = 1'b1;
        rk_idx = 4'd0;
        do_load(KEY_B);
        rk_req = 1'b0;
        chk("same_cycle_rd_err", rk_err, 0);
        chk("same_cycle_rd_data", rk_data, KEY_A);
        chk("same_cycle_kx_key", kx_key, KEY_B);
        chk("same_cycle_kv_cleared", keys_valid, 0);
        wait_done("stale2");
        rd(4'd0, 1'b0, KEY_B);
        rd(4'd10, 1'b0, golden[10]);
        stale_hold = 1;

        // key_load during round 4 is ignored
        do_load(KEY_A);
        wait_acks(3);
        key_in = KEY_B;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("midload_kx_key", kx_key, KEY_A);
        chk("midload_busy", busy, 1);
        wait_done("midload");
        rd(4'd0, 1'b0, KEY_A);

        // Stalled round 3 times out after exactly 64 cycles in WAIT
        stall_round = 3;
        do_load(KEY_A);
        wait_acks(2);
        k = 0;
        while (!error && k < 200) begin
            tick();
            k++;
        end
        chk("timeout_cycles", k, 64);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_kx_enable", kx_enable, 0);
        chk("timeout_keys_valid", keys_valid, 0);
        stall_round = 99;
        do_load(KEY_A);
        chk("reload_clears_error", error, 0);
        chk("reload_busy", busy, 1);
        wait_done("recover");
        rd(4'd7, 1'b0, golden[7]);

        // Asynchronous reset mid-expansion
        do_load(KEY_A);
        wait_acks(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_kx_enable", kx_enable, 0);
        chk("post_reset_keys_valid", keys_valid, 0);
        rd(4'd1, 1'b1, 128'h0);

        // Expansion FSM error in round 7
        do_load(KEY_A);
        wait_acks(6);
        inj_err = 1'b1;
        tick();
        inj_err = 1'b0;
        chk("kxerr_error", error, 1);
        chk("kxerr_busy", busy, 0);
        chk("kxerr_kx_enable", kx_enable, 0);
        chk("kxerr_keys_valid", keys_valid, 0);
        tick(); tick();
        chk("kxerr_ack_count", ack_cnt - ack_base, 6);
        rd(4'd3, 1'b1, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Round-key scheduler for the AES-128 core. Sequences the key-expansion block through all ten rounds on each new cipher key, stores the eleven round keys, and serves them by index to the cipher round datapath. It sits between the top-level key load interface and the cipher datapath, and it owns the expansion block's `enable` / `key_ready` / `key_ack` handshake.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent waiting for any single round key before the block flags an error.
- `clk` input, 1: the only clock; all logic is on its rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `key_load` input, 1: single-cycle request to expand `key_in`.
- `key_in` input, 128: cipher key.
- `kx_enable` output, 1: enable to key expansion; expansion starts on its rising edge.
- `kx_key` output, 128: key presented to key expansion; registered and held stable.
- `kx_key_ack` output, 1: one-cycle pulse accepting the current round key.
- `kx_key_ready` input, 1: the expansion block's round key is valid.
- `kx_key_transform` input, 4: round number of the expansion block's current output.
- `kx_key_out` input, 128: expanded round key.
- `kx_state_error` input, 1: the expansion block's FSM error flag.
- `rk_req` input, 1: round-key read request.
- `rk_idx` input, 4: requested round, 0..10.
- `rk_valid` output, 1: read response strobe.
- `rk_data` output, 128: round key.
- `rk_err` output, 1: qualifies `rk_valid`; the read was invalid.
- `keys_valid` output, 1: all 11 round keys are stored and current.
- `busy` output, 1: expansion is in progress.
- `error` output, 1: sticky error flag; cleared by the next accepted `key_load`.
- Reset values: every output is 0, including `kx_key`, `rk_data`, and the stored round keys.

## Operation
- States: IDLE, START, WAIT, ACK, DONE, ERROR.
- IDLE / DONE / ERROR, with `key_load`=1:
  - capture `key_in` into `kx_key` and into rk[0];
  - `exp_idx`←1; `keys_valid`, `error`←0; `busy`←1; go to START.
- `key_load` in START, WAIT or ACK is ignored, with no side effects.
- START: `kx_enable`←1; clear the timeout counter; go to WAIT.
- WAIT: capture when `kx_key_ready`=1 and `kx_key_transform`==`exp_idx`.
  - On capture: rk[`exp_idx`]←`kx_key_out`; `kx_key_ack`←1; go to ACK.
  - While waiting, increment the timeout counter.
  - The match guard on `kx_key_transform` is mandatory. `kx_key_ready` stays high for one cycle after an ack, and the guard prevents a double capture.
- ACK:
  - `kx_key_ack`←0.
  - If `exp_idx`==10: go to DONE, with `kx_enable`←0, `busy`←0, `keys_valid`←1.
  - Otherwise: `exp_idx`←`exp_idx`+1, clear the timeout counter, go to WAIT.
- Errors:
  - Any of START/WAIT/ACK with `kx_state_error`=1 → ERROR.
  - WAIT with the timeout counter == `TIMEOUT_CYCLES`−1 → ERROR.
  - On entry to ERROR: `kx_enable`←0, `busy`←0, `keys_valid`←0, `error`←1.
- Read port, one access per cycle, independent of the FSM:
  - `rk_req` at cycle N → `rk_valid`=1 for exactly one cycle at N+1.
  - If `keys_valid`=1 and `rk_idx`≤10: `rk_data`=rk[`rk_idx`], `rk_err`=0.
  - Otherwise: `rk_data`=0, `rk_err`=1.
  - `rk_data` holds its value between reads.
- `key_load` in the same cycle as `rk_req` (from DONE): the read is evaluated with the pre-load `keys_valid`=1 and returns the old key.
- Reset mid-expansion: all state returns to reset values. The expansion block shares `reset_n` and restarts cleanly.

## Timing
- `key_load` at cycle 0 → `busy` and `kx_key` valid at 1 → `kx_enable` high at 2.
- Round-key capture latency follows the expansion block: 5 cycles minimum per round from ack to the next `kx_key_ready`.
- `kx_key_ack` is always exactly one cycle wide. At most one ack is issued per round.
- `keys_valid` rises one cycle after the round-10 ack pulse.
- `kx_enable` is low for at least one cycle (DONE/ERROR) before any reload, which guarantees a fresh rising edge.

## Structure
- Shared package `aes_pkg`:
  - enum `key_sched_state_t`;
  - constants `AES_NUM_ROUNDS`=10, `AES_NUM_RKEYS`=11, `AES_KEY_W`=128.
- Sub-module `aes_rkey_store`: 11×128 register file with one synchronous write port and one registered read port with the range check. The FSM, counters and handshake stay in the top module.

## Test plan
- Reset, then no stimulus → all outputs 0; `rk_req` with `rk_idx`=0 → `rk_valid`=1, `rk_err`=1, `rk_data`=0.
- `key_load` with `key_in`=128'h2b7e151628aed2a6abf7158809cf4f3c → exactly 10 `kx_key_ack` pulses, then `keys_valid`=1.
  - `rk_idx`=0 returns the loaded key.
  - `rk_idx`=1..10 match the golden model of the expansion datapath.
- `kx_key_ready` held high 2 cycles after an ack with a stale `kx_key_transform` → no second capture; ack count stays 10.
- `key_load` pulsed during round 4 → ignored; `kx_key` is unchanged; expansion completes with the original key.
- Stub holds `kx_key_ready`=0 for 64 cycles in WAIT → `error`=1, `busy`=0, `kx_enable`=0.
  - Next `key_load` clears `error`.
- `kx_state_error` pulse in round 7 → ERROR, `keys_valid`=0.
- `reset_n` asserted mid-expansion → all outputs 0 immediately (asynchronous).
- `rk_req` with `rk_idx`=11 after completion → `rk_err`=1.
